// File: rtl/platformniossdram_pio_in.sv
// Avalon-MM parallel input port: synchronised inputs, sticky edge capture, masked irq.
// Optional PIO_IN_BIT_CLEAR_EN: edge_capture clears per written 1-bit instead of wholesale.
module platformniossdram_pio_in #(
    parameter int WIDTH       = 16,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    typedef enum logic {WARMUP, ARMED} state_t;

    localparam logic [2:0] WARM_LOAD = 3'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] raw_edges;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] clr_bits;
    logic [WIDTH-1:0] cap_next;
    logic [WIDTH-1:0] mask_next;
    logic [31:0]      rd_val;
    logic [2:0]       warm_cnt;
    state_t           state;
    logic             rd_en;
    logic             wr_en;
    logic             unused_wr;

    assign sync_in   = sync_q[SYNC_STAGES-1];
    assign rd_en     = chipselect && !read_n;
    assign wr_en     = chipselect && !write_n;
    assign unused_wr = ^writedata;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev <= sync_in;
        end
    end

    // The chain refills from zero after reset; edges stay masked until it settles.
    always_ff @(posedge clk) begin
        if (reset) begin
            warm_cnt <= WARM_LOAD;
            state    <= WARMUP;
        end else begin
            if (warm_cnt != 3'd0) warm_cnt <= warm_cnt - 3'd1;
            if (state == WARMUP && warm_cnt == 3'd1) state <= ARMED;
        end
    end

    always_comb begin
        raw_edges = sync_in & ~prev;
        case (EDGE_TYPE)
            1:       raw_edges = ~sync_in & prev;
            2:       raw_edges = sync_in ^ prev;
            default: raw_edges = sync_in & ~prev;
        endcase
        edges = (state == ARMED) ? raw_edges : '0;
    end

    always_comb begin
        clr_bits = '0;
        if (wr_en && address == 2'd3) begin
`ifdef PIO_IN_BIT_CLEAR_EN
            clr_bits = writedata[WIDTH-1:0];
`else
            clr_bits = '1;
`endif
        end
        // A fresh edge overrides a clear landing in the same cycle.
        cap_next  = (edge_capture & ~clr_bits) | edges;
        mask_next = irq_mask;
        if (wr_en && address == 2'd2) mask_next = writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_val = '0;
        case (address)
            2'd0:    rd_val[WIDTH-1:0] = sync_in;
            2'd2:    rd_val[WIDTH-1:0] = irq_mask;
            2'd3:    rd_val[WIDTH-1:0] = edge_capture;
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            edge_capture <= '0;
            irq_mask     <= '0;
            irq          <= 1'b0;
            readdata     <= '0;
        end else begin
            edge_capture <= cap_next;
            irq_mask     <= mask_next;
            irq          <= |(cap_next & mask_next);
            if (rd_en) readdata <= rd_val;
        end
    end

endmodule

// File: tb/tb_platformniossdram_pio_in.sv
// Scoreboard bench for platformniossdram_pio_in: rising-edge and any-edge instances.
// Expected read data is queued at the strobe and compared one cycle later.
module tb_platformniossdram_pio_in;

    typedef struct {
        string       tag;
        logic [31:0] exp;
        bit          any;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        read_n = 1'b1;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [15:0] in_port = 16'hFFFF;
    logic [15:0] in_any = 16'h0000;
    logic [31:0] readdata;
    logic [31:0] readdata_a;
    logic        irq;
    logic        irq_a;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    platformniossdram_pio_in #(.WIDTH(16), .EDGE_TYPE(0), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata), .in_port(in_port), .irq(irq)
    );

    platformniossdram_pio_in #(.WIDTH(16), .EDGE_TYPE(2), .SYNC_STAGES(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(readdata_a), .in_port(in_any), .irq(irq_a)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xfer(input logic [1:0] a, input bit r, input bit w,
                        input logic [31:0] wd, input logic [31:0] ex,
                        input string tag, input bit any);
        exp_t e;
        address    = a;
        chipselect = 1'b1;
        read_n     = !r;
        write_n    = !w;
        writedata  = wd;
        if (r) begin
            e.tag = tag;
            e.exp = ex;
            e.any = any;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        if (r) begin
            e = sb.pop_front();
            check(e.tag, e.any ? readdata_a : readdata, e.exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] ex, input string tag);
        xfer(a, 1'b1, 1'b0, 32'h0, ex, tag, 1'b0);
    endtask

    task automatic rd_any(input logic [1:0] a, input logic [31:0] ex, input string tag);
        xfer(a, 1'b1, 1'b0, 32'h0, ex, tag, 1'b1);
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] wd);
        xfer(a, 1'b0, 1'b1, wd, 32'h0, "", 1'b0);
    endtask

    initial begin
        logic [31:0] exp_cap;
        logic        exp_irq;

        step(2);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_irq_any", 32'(irq_a), 32'h0);
        reset = 1'b0;
        step(10);
        rd(2'd3, 32'h0, "warmup_cap");
        rd(2'd0, 32'h0000FFFF, "data_ffff");
        step(1);
        check("readdata_hold", readdata, 32'h0000FFFF);
        rd(2'd1, 32'h0, "reserved");

        in_port = 16'h0000;
        step(4);
        rd(2'd3, 32'h0, "fall_ignored");
        xfer(2'd2, 1'b1, 1'b1, 32'h1, 32'h0, "rdwr_prewrite", 1'b0);
        rd(2'd2, 32'h1, "mask_1");
        in_port = 16'h0001;
        step(2);
        check("lat_irq_early", 32'(irq), 32'h0);
        step(1);
        check("lat_irq_set", 32'(irq), 32'h1);
        rd(2'd3, 32'h1, "cap_bit0");
        in_port = 16'h0000;
        step(4);
        rd(2'd3, 32'h1, "fall_no_new");
        check("irq_held", 32'(irq), 32'h1);

        wr(2'd3, 32'hFFFF);
        check("clr_irq", 32'(irq), 32'h0);
        rd(2'd3, 32'h0, "clr_all");
        in_port = 16'h0009;
        step(4);
        wr(2'd2, 32'h9);
        rd(2'd3, 32'h9, "cap_09");
        check("irq_09", 32'(irq), 32'h1);
        wr(2'd3, 32'h1);
`ifdef PIO_IN_BIT_CLEAR_EN
        exp_cap = 32'h8;
        exp_irq = 1'b1;
`else
        exp_cap = 32'h0;
        exp_irq = 1'b0;
`endif
        check("clr1_irq", 32'(irq), 32'(exp_irq));
        rd(2'd3, exp_cap, "clr1_cap");

        wr(2'd3, 32'hFFFF);
        in_port = 16'h0029;
        step(2);
        wr(2'd3, 32'hFFFF);
        rd(2'd3, 32'h20, "edge_beats_clr");
        check("irq_b5_masked", 32'(irq), 32'h0);

        wr(2'd2, 32'h0);
        in_any = 16'h0080;
        step(4);
        in_any = 16'h0000;
        step(4);
        rd_any(2'd3, 32'h80, "any_cap7");
        check("any_irq_masked", 32'(irq_a), 32'h0);
        wr(2'd2, 32'h80);
        check("any_irq_unmask", 32'(irq_a), 32'h1);
        check("dut_irq_m80", 32'(irq), 32'h0);

        in_port = 16'h0000;
        step(4);
        wr(2'd3, 32'hFFFF);
        wr(2'd2, 32'hFFFF);
        in_port = 16'h00FF;
        step(4);
        rd(2'd3, 32'hFF, "pre_reset_cap");
        check("pre_reset_irq", 32'(irq), 32'h1);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("mid_rst_readdata", readdata, 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rd(2'd2, 32'h0, "mid_rst_mask");
        rd(2'd3, 32'h0, "mid_rst_cap");
        step(8);
        rd(2'd3, 32'h0, "rewarm_cap");
        check("rewarm_irq", 32'(irq), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
